hold_reg_fifo: RTL and testbench

Parametrised successor to the single 8-bit load register used in the UART data path. Holds up to DEPTH words of WIDTH bits in first-in/first-out order, with a load/read strobe interface and full/empty status. Adds a sticky overrun flag so a UART TX holding stage or RX buffer can absorb back-to-back bytes without loss. Sits between the bus-side register interface and the TX shifter, or between the RX shifter and the bus.

---
 rtl/hold_reg_pkg.sv | 16 +
 rtl/hold_reg_fifo_ctrl.sv | 104 ++++++++++
 rtl/hold_reg_fifo.sv | 91 +++++++++
 tb/tb_hold_reg_fifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/hold_reg_pkg.sv
// hold_reg_pkg: shared defaults and helpers for the UART holding FIFO.
package hold_reg_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_HOLD_DEPTH = 4;

  // Pointer width for a given depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/hold_reg_fifo_ctrl.sv
// hold_reg_fifo_ctrl: pointers, occupancy count, full/empty status and the
// sticky overrun flag of the holding FIFO.
// Optional macro HOLD_REG_FIFO_AFULL_EN adds AF_LEVEL and the afull output.
module hold_reg_fifo_ctrl
  import hold_reg_pkg::*;
#(
  parameter int DEPTH = UART_HOLD_DEPTH,
`ifdef HOLD_REG_FIFO_AFULL_EN
  parameter int AF_LEVEL = DEPTH - 1,
`endif
  parameter int AW = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          rd,
  input  logic          clr_ovf,
  output logic          push,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr_nxt,
  output logic          empty_nxt,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
`ifdef HOLD_REG_FIFO_AFULL_EN
  output logic          afull,
`endif
  output logic          ovf
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
`ifdef HOLD_REG_FIFO_AFULL_EN
  localparam logic [AW:0] AF_C = (AW+1)'(AF_LEVEL);
  logic afull_d, afull_q;
`endif

  logic [AW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [AW:0]   count_d, count_q;
  logic          empty_d, empty_q, full_d, full_q, ovf_d, ovf_q;
  logic          pop;

  // Next-state for pointers, count, status; a full FIFO still accepts a
  // load when the same cycle pops, and a dropped load raises ovf.
  always_comb begin
    pop      = rd && !empty_q;
    push     = load && (!full_q || rd);
    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (load && full_q && !rd) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    empty_d = (count_d == (AW+1)'(0));
    full_d  = (count_d == DEPTH_C);
`ifdef HOLD_REG_FIFO_AFULL_EN
    afull_d = (count_d >= AF_C);
`endif
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef HOLD_REG_FIFO_AFULL_EN
      afull_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
`ifdef HOLD_REG_FIFO_AFULL_EN
      afull_q  <= afull_d;
`endif
    end
  end

  assign wr_ptr     = wr_ptr_q;
  assign rd_ptr_nxt = rd_ptr_d;
  assign empty_nxt  = empty_d;
  assign count      = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign ovf        = ovf_q;
`ifdef HOLD_REG_FIFO_AFULL_EN
  assign afull      = afull_q;
`endif

endmodule

// File: rtl/hold_reg_fifo.sv
// hold_reg_fifo: DEPTH x WIDTH show-ahead holding FIFO for the UART data path.
// Q is registered from the post-edge head, so a word written into an empty
// FIFO is visible right after its load edge without a path from D to Q.
// Optional macro HOLD_REG_FIFO_AFULL_EN adds AF_LEVEL and the afull output.
module hold_reg_fifo
  import hold_reg_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = UART_HOLD_DEPTH,
`ifdef HOLD_REG_FIFO_AFULL_EN
  parameter int AF_LEVEL = DEPTH - 1,
`endif
  localparam int AW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             rd,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] Q,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
`ifdef HOLD_REG_FIFO_AFULL_EN
  output logic             afull,
`endif
  output logic             ovf
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] q_d, q_q;
  logic             push_s, empty_nxt_s;
  logic [AW-1:0]    wr_ptr_s, rd_ptr_nxt_s;

  hold_reg_fifo_ctrl #(
    .DEPTH    (DEPTH),
`ifdef HOLD_REG_FIFO_AFULL_EN
    .AF_LEVEL (AF_LEVEL),
`endif
    .AW       (AW)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .rd         (rd),
    .clr_ovf    (clr_ovf),
    .push       (push_s),
    .wr_ptr     (wr_ptr_s),
    .rd_ptr_nxt (rd_ptr_nxt_s),
    .empty_nxt  (empty_nxt_s),
    .count      (count),
    .empty      (empty),
    .full       (full),
`ifdef HOLD_REG_FIFO_AFULL_EN
    .afull      (afull),
`endif
    .ovf        (ovf)
  );

  // Storage array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_s] <= D;
    end
  end

  // Head value as it will stand after this edge: zero when empty, the
  // incoming word when it lands in the head slot, otherwise stored data.
  always_comb begin
    if (empty_nxt_s) begin
      q_d = '0;
    end else if (push_s && (wr_ptr_s == rd_ptr_nxt_s)) begin
      q_d = D;
    end else begin
      q_d = mem_q[rd_ptr_nxt_s];
    end
  end

  // Registered head output.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_hold_reg_fifo.sv
// tb_hold_reg_fifo: scoreboard bench for hold_reg_fifo (WIDTH=8, DEPTH=4).
module tb_hold_reg_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] D = '0;
  logic             rd = 1'b0;
  logic             clr_ovf = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             empty, full, ovf;
  logic [2:0]       count;
`ifdef HOLD_REG_FIFO_AFULL_EN
  logic             afull;
`endif

  int vectors = 0;
  int miscompares = 0;

  // scoreboard / model state
  logic [WIDTH-1:0] sb[$];
  logic             ovf_m = 1'b0;
  logic             pop_chk;
  logic [WIDTH-1:0] pop_exp, pop_obs;

  hold_reg_fifo #(
    .WIDTH    (WIDTH),
`ifdef HOLD_REG_FIFO_AFULL_EN
    .AF_LEVEL (3),
`endif
    .DEPTH    (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .D       (D),
    .rd      (rd),
    .clr_ovf (clr_ovf),
    .Q       (Q),
    .empty   (empty),
    .full    (full),
    .count   (count),
`ifdef HOLD_REG_FIFO_AFULL_EN
    .afull   (afull),
`endif
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // One clock of stimulus: update the model, record the expected popped
  // word with the head observed before the edge, then step past the edge.
  task automatic cyc(input logic r, input logic l, input logic [WIDTH-1:0] d,
                     input logic rdi, input logic clr);
    bit full_m, empty_m, do_push, do_pop;
    reset = r; load = l; D = d; rd = rdi; clr_ovf = clr;
    full_m  = (sb.size() == DEPTH);
    empty_m = (sb.size() == 0);
    do_pop  = rdi && !empty_m;
    do_push = l && (!full_m || rdi);
    pop_chk = 1'b0;
    if (r) begin
      sb.delete();
      ovf_m = 1'b0;
    end else begin
      if (do_pop) begin
        pop_chk = 1'b1;
        pop_exp = sb.pop_front();
        pop_obs = Q;
      end
      if (do_push) sb.push_back(d);
      if (l && full_m && !rdi) ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;
    end
    @(posedge clk);
    #1;
    reset = 1'b0; load = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b exp 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b exp 0", full); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
    vectors++; if (Q !== 8'h00) begin miscompares++; $display("FAIL reset_q got %h exp 00", Q); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b exp 0", ovf); end
  endtask

  task automatic test_single();
    cyc(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    vectors++; if (Q !== sb[0]) begin miscompares++; $display("FAIL single_q got %h exp %h", Q, sb[0]); end
    vectors++; if (count !== 3'(sb.size())) begin miscompares++; $display("FAIL single_count got %0d exp %0d", count, sb.size()); end
    vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL single_empty got %b exp 0", empty); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    vectors++; if (!pop_chk || pop_obs !== pop_exp) begin miscompares++; $display("FAIL single_pop got %h exp %h", pop_obs, pop_exp); end
    vectors++; if (empty !== 1'b1 || Q !== 8'h00) begin miscompares++; $display("FAIL single_drained got empty=%b q=%h exp empty=1 q=00", empty, Q); end
  endtask

  task automatic test_fill_overrun();
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    vectors++; if (full !== 1'b1 || count !== 3'd4) begin miscompares++; $display("FAIL fill_full got full=%b count=%0d exp full=1 count=4", full, count); end
    cyc(1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
    vectors++; if (ovf !== ovf_m || ovf_m !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b exp %b", ovf, ovf_m); end
    vectors++; if (count !== 3'd4 || Q !== sb[0]) begin miscompares++; $display("FAIL ovf_unchanged got count=%0d q=%h exp 4 %h", count, Q, sb[0]); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      vectors++; if (!pop_chk || pop_obs !== pop_exp) begin miscompares++; $display("FAIL drain_%0d got %h exp %h", i, pop_obs, pop_exp); end
    end
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); // read while empty: ignored
    vectors++; if (empty !== 1'b1 || count !== 3'd0 || ovf !== ovf_m) begin miscompares++; $display("FAIL empty_rd got empty=%b count=%0d ovf=%b", empty, count, ovf); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    vectors++; if (ovf !== ovf_m) begin miscompares++; $display("FAIL ovf_clr got %b exp %b", ovf, ovf_m); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    vectors++; if (!pop_chk || pop_obs !== pop_exp) begin miscompares++; $display("FAIL full_both_pop got %h exp %h", pop_obs, pop_exp); end
    vectors++; if (count !== 3'd4 || ovf !== 1'b0) begin miscompares++; $display("FAIL full_both got count=%0d ovf=%b exp 4 0", count, ovf); end
    // set wins over clear in the same cycle
    cyc(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
    vectors++; if (ovf !== ovf_m || ovf_m !== 1'b1) begin miscompares++; $display("FAIL ovf_priority got %b exp %b", ovf, ovf_m); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      vectors++; if (!pop_chk || pop_obs !== pop_exp) begin miscompares++; $display("FAIL simul_drain_%0d got %h exp %h", i, pop_obs, pop_exp); end
    end
    vectors++; if (pop_exp !== 8'h55) begin miscompares++; $display("FAIL last_word got %h exp 55", pop_obs); end
    cyc(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    vectors++; if (count !== 3'd1 || Q !== 8'h3C || ovf !== 1'b0) begin miscompares++; $display("FAIL empty_both got count=%0d q=%h ovf=%b exp 1 3c 0", count, Q, ovf); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
      vectors++; if (!pop_chk || pop_obs !== pop_exp) begin miscompares++; $display("FAIL wrap_%0d got %h exp %h", i, pop_obs, pop_exp); end
    end
    for (int i = 0; i < 60; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (pop_chk) begin
        vectors++; if (pop_obs !== pop_exp) begin miscompares++; $display("FAIL rand_pop_%0d got %h exp %h", i, pop_obs, pop_exp); end
      end
      vectors++;
      if (count !== 3'(sb.size()) || ovf !== ovf_m || Q !== (sb.size() != 0 ? sb[0] : 8'h00)) begin
        miscompares++; $display("FAIL rand_state_%0d got count=%0d q=%h ovf=%b exp count=%0d ovf=%b", i, count, Q, ovf, sb.size(), ovf_m);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
`ifdef HOLD_REG_FIFO_AFULL_EN
      vectors++; if (afull !== (i == 2)) begin miscompares++; $display("FAIL afull_%0d got %b exp %b", i, afull, (i == 2)); end
`endif
    end
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL pre_reset_count got %0d exp 3", count); end
    cyc(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
    vectors++; if (count !== 3'd0 || empty !== 1'b1 || Q !== 8'h00) begin miscompares++; $display("FAIL reset_mid got count=%0d empty=%b q=%h exp 0 1 00", count, empty, Q); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overrun();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
